alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Instruction-decode pipeline stage that produces the `op`/`operand_a`/`operand_b` triple consumed by the execute-stage ALU. It takes a fetched RV32I instruction plus register-file read data and decodes it into the ALU's 4-bit operation code. It registers the result into a single-entry ID/EX buffer with valid/ready handshaking on both sides and a flush input. It is the producer end of the ALU control interface, sitting between fetch/regfile and execute.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk` input 1: clock, all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: an instruction is presented on `in_*`.
- `in_ready` output 1: the stage accepts the instruction this cycle.
- `in_instr` input 32: raw instruction word.
- `in_pc` input 32: PC of `in_instr`.
- `rs1_data` input 32: register-file value for `in_instr[19:15]`, valid with `in_valid`.
- `rs2_data` input 32: register-file value for `in_instr[24:20]`, valid with `in_valid`.
- `flush` input 1: discard the buffered entry and any instruction accepted this cycle.
- `out_valid` output 1: the buffered entry is valid.
- `out_ready` input 1: the execute stage consumes the entry this cycle.
- `out_alu_op` output 4: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SRA=5, SRL=6, SLL=7, SLT=8.
- `out_operand_a` output 32: ALU operand A.
- `out_operand_b` output 32: ALU operand B.
- `out_rd` output 5: destination register.
- `out_reg_write` output 1: write-back enable.
- `out_illegal` output 1: the instruction is unsupported by this stage/ALU.
- `out_pc` output 32: PC of the buffered instruction.

## Operation
- Decode is combinational on `in_*`; the result is captured into the buffer on a transfer (`in_valid && in_ready`).
- `in_ready = !out_valid || out_ready` (combinational, independent of `flush`).
- OP (opcode 0110011), selected by funct7/funct3:
  - funct7 0000000: funct3 000→ADD, 111→AND, 110→OR, 100→XOR, 001→SLL, 101→SRL, 010→SLT.
  - funct7 0100000: funct3 000→SUB, 101→SRA.
  - Operands: a=`rs1_data`, b=`rs2_data`.
- OP-IMM (0010011): ADDI/ANDI/ORI/XORI/SLTI map as above with b=sign-extended `instr[31:20]`.
  - SLLI requires funct7=0000000.
  - SRLI/SRAI use funct7 0000000/0100000.
  - For shifts, b={27'b0, `instr[24:20]`}.
- LUI (0110111): ADD, a=0, b={`instr[31:12]`,12'b0}.
- AUIPC (0010111): ADD, a=`in_pc`, b={`instr[31:12]`,12'b0}.
- LOAD (0000011): ADD, a=`rs1_data`, b=sign-extended I-immediate.
- Any other opcode/funct combination is illegal, including SLTU/SLTIU (no ALU support), funct7=0000001 (M extension), SYSTEM, branches, jumps and stores.
- Illegal entries: `out_illegal`=1, `out_alu_op`=ADD, operands 0, `out_reg_write`=0; `out_rd`/`out_pc` still carry instruction fields.
- `out_reg_write` = legal && `rd`≠0.
- Sign extension fills bits [31:12] with `instr[31]`.

## Timing
- Reset: `out_valid`=0; `out_alu_op`, operands, `out_rd`, `out_pc`=0; `out_reg_write`=0, `out_illegal`=0. `rst` overrides `flush` and the handshakes.
- Latency: 1 cycle. An instruction transferred at edge N appears on `out_*` with `out_valid`=1 after edge N.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- Hold: while `out_valid && !out_ready`, all `out_*` stay stable and `in_ready`=0.
- Consume with refill: `out_valid && out_ready && in_valid` in the same cycle loads the new entry; `out_valid` stays 1.
- Consume without refill: `out_valid && out_ready && !in_valid` clears `out_valid` next cycle. Data outputs may keep stale values while `out_valid`=0.
- Flush: `flush`=1 at an edge sets `out_valid`=0 after that edge, regardless of `in_valid`/`out_ready`. An instruction handshaked that cycle is dropped. `flush` has priority over load.
- Reset asserted mid-stall: the buffer clears next edge; `in_ready`=1 the cycle after.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, op=0, a=5, b=7, rd=3, reg_write=1, illegal=0.
- SRAI x5,x6,3 (0x40335293), rs1=0x80000000 → op=5, b=3, rd=5. ADDI x1,x0,-1 (0xFFF00093) → op=0, b=0xFFFFFFFF.
- LUI x1,0x12345 (0x123450B7) → op=0, a=0, b=0x12345000. AUIPC at pc=0x100 (0x00001097) → a=0x100, b=0x1000.
- Backpressure: SUB (0x402081B3) accepted, then out_ready=0 for 3 cycles → op=1 held stable, in_ready=0. Raise out_ready with a new in_valid → back-to-back transfer, out_valid never drops.
- Illegal: MUL (0x022081B3) and SLTU (0x0020B1B3) → illegal=1, reg_write=0, op=0, operands 0. ADD with rd=x0 → reg_write=0, illegal=0.
- Flush/reset: flush=1 while out_valid=1 and in_valid=1 → out_valid=0 next cycle and the input is lost. rst=1 during a stall → all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_decode_stage_if.sv
// Handshake and data bundle between fetch/regfile, the decode stage, and the execute-stage ALU.
// master is the decode stage's view; slave is the surrounding pipeline's view.
interface alu_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [31:0]     in_pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_alu_op;
  logic [XLEN-1:0] out_operand_a;
  logic [XLEN-1:0] out_operand_b;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_illegal;
  logic [31:0]     out_pc;

  modport master (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, out_alu_op, out_operand_a, out_operand_b,
           out_rd, out_reg_write, out_illegal, out_pc
  );

  modport slave (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, out_alu_op, out_operand_a, out_operand_b,
           out_rd, out_reg_write, out_illegal, out_pc
  );
endinterface

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: maps an instruction onto the ALU op/operand triple and holds it
// in a single-entry ID/EX buffer with valid/ready handshaking and flush.
module alu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  alu_decode_stage_if.master  bus
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
    ALU_SRA = 4'd5, ALU_SRL = 4'd6, ALU_SLL = 4'd7, ALU_SLT = 4'd8
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [XLEN-1:0] imm_i, imm_u, shamt;
  logic        unused_rs1_idx;

  assign instr          = bus.in_instr;
  assign opcode         = instr[6:0];
  assign funct3         = instr[14:12];
  assign funct7         = instr[31:25];
  assign imm_i          = {{20{instr[31]}}, instr[31:20]};
  assign imm_u          = {instr[31:12], 12'b0};
  assign shamt          = {27'b0, instr[24:20]};
  assign unused_rs1_idx = ^instr[19:15];

  logic            dec_legal;
  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_a, dec_b;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_ADD;
    dec_a     = '0;
    dec_b     = '0;
    unique case (opcode)
      OPC_OP: begin
        dec_a = bus.rs1_data;
        dec_b = bus.rs2_data;
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
          unique case (funct3)
            3'b000:  dec_op = ALU_ADD;
            3'b111:  dec_op = ALU_AND;
            3'b110:  dec_op = ALU_OR;
            3'b100:  dec_op = ALU_XOR;
            3'b001:  dec_op = ALU_SLL;
            3'b101:  dec_op = ALU_SRL;
            3'b010:  dec_op = ALU_SLT;
            default: dec_legal = 1'b0;
          endcase
        end else if (funct7 == F7_ALT) begin
          dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
          dec_op    = (funct3 == 3'b101) ? ALU_SRA : ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        dec_a     = bus.rs1_data;
        dec_b     = imm_i;
        dec_legal = 1'b1;
        unique case (funct3)
          3'b000:  dec_op = ALU_ADD;
          3'b111:  dec_op = ALU_AND;
          3'b110:  dec_op = ALU_OR;
          3'b100:  dec_op = ALU_XOR;
          3'b010:  dec_op = ALU_SLT;
          3'b001: begin
            dec_op    = ALU_SLL;
            dec_b     = shamt;
            dec_legal = (funct7 == F7_BASE);
          end
          3'b101: begin
            dec_op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_b     = shamt;
            dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_b     = imm_u;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_a     = bus.in_pc;
        dec_b     = imm_u;
      end
      OPC_LOAD: begin
        dec_legal = 1'b1;
        dec_a     = bus.rs1_data;
        dec_b     = imm_i;
      end
      default: ;
    endcase
    // Illegal entries must present a harmless ADD 0,0 to the ALU.
    if (!dec_legal) begin
      dec_op = ALU_ADD;
      dec_a  = '0;
      dec_b  = '0;
    end
  end

  logic            valid_q, valid_d;
  alu_op_e         op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [4:0]      rd_q, rd_d;
  logic            we_q, we_d;
  logic            ill_q, ill_d;
  logic [31:0]     pc_q, pc_d;
  logic            load;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    we_d    = we_q;
    ill_d   = ill_q;
    pc_d    = pc_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      op_d    = dec_op;
      a_d     = dec_a;
      b_d     = dec_b;
      rd_d    = instr[11:7];
      we_d    = dec_legal && (instr[11:7] != 5'd0);
      ill_d   = !dec_legal;
      pc_d    = bus.in_pc;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      ill_q   <= ill_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.out_alu_op    = op_q;
  assign bus.out_operand_a = a_q;
  assign bus.out_operand_b = b_q;
  assign bus.out_rd        = rd_q;
  assign bus.out_reg_write = we_q;
  assign bus.out_illegal   = ill_q;
  assign bus.out_pc        = pc_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized bench for alu_decode_stage: an instruction-level reference model plus a
// one-entry buffer model, checked every negedge, with directed literal checks up front.
module tb_alu_decode_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_decode_stage_if #(.XLEN(32)) bus ();

  alu_decode_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: op index -1 marks an unsupported encoding.
  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    int          rmap [8];
    int          op;
    int          f3;
    logic [6:0]  f7;
    logic [31:0] a, b;
    ent_t        e;
    rmap = '{0, 7, 8, -1, 4, 6, 3, 2};  // indexed by funct3: ADD SLL SLT SLTU XOR SRL OR AND
    f3 = int'(ins[14:12]);
    f7 = ins[31:25];
    op = -1;
    a  = 32'd0;
    b  = 32'd0;
    case (ins[6:0])
      7'h33: begin
        a = r1;
        b = r2;
        if (f7 == 7'h00) op = rmap[f3];
        else if (f7 == 7'h20 && f3 == 0) op = 1;
        else if (f7 == 7'h20 && f3 == 5) op = 5;
      end
      7'h13: begin
        a = r1;
        if (f3 == 1) begin
          b  = {27'd0, ins[24:20]};
          op = (f7 == 7'h00) ? 7 : -1;
        end else if (f3 == 5) begin
          b  = {27'd0, ins[24:20]};
          op = (f7 == 7'h00) ? 6 : (f7 == 7'h20) ? 5 : -1;
        end else begin
          b  = 32'($signed(ins[31:20]));
          op = rmap[f3];
        end
      end
      7'h37: begin op = 0; a = 32'd0; b = {ins[31:12], 12'd0}; end
      7'h17: begin op = 0; a = pc;    b = {ins[31:12], 12'd0}; end
      7'h03: begin op = 0; a = r1;    b = 32'($signed(ins[31:20])); end
      default: ;
    endcase
    e.rd = ins[11:7];
    e.pc = pc;
    if (op < 0) begin
      e.ill = 1'b1; e.we = 1'b0; e.op = 4'd0; e.a = 32'd0; e.b = 32'd0;
    end else begin
      e.ill = 1'b0; e.we = (ins[11:7] != 5'd0); e.op = 4'(op); e.a = a; e.b = b;
    end
    return e;
  endfunction

  // Buffer model: updated on each rising edge from the inputs held across that edge.
  logic m_valid = 1'b0;
  logic m_zero  = 1'b1;
  ent_t m_ent   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_ent   = '0;
      m_zero  = 1'b1;
    end else if (bus.flush) begin
      m_valid = 1'b0;
    end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
      m_valid = 1'b1;
      m_ent   = ref_decode(bus.in_instr, bus.in_pc, bus.rs1_data, bus.rs2_data);
      m_zero  = 1'b0;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
  end

  bit started = 1'b0;
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("in_ready",  32'(bus.in_ready),  32'(!m_valid || bus.out_ready));
      if (m_valid || m_zero) begin
        chk("out_alu_op",    32'(bus.out_alu_op),    32'(m_ent.op));
        chk("out_operand_a", bus.out_operand_a,      m_ent.a);
        chk("out_operand_b", bus.out_operand_b,      m_ent.b);
        chk("out_rd",        32'(bus.out_rd),        32'(m_ent.rd));
        chk("out_reg_write", 32'(bus.out_reg_write), 32'(m_ent.we));
        chk("out_illegal",   32'(bus.out_illegal),   32'(m_ent.ill));
        chk("out_pc",        bus.out_pc,             m_ent.pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid  = 1'b1;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.rs1_data  = r1;
    bus.rs2_data  = r2;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    step();
    bus.in_valid  = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [12];
    logic [31:0] ins;
    opcs = '{7'h33, 7'h33, 7'h33, 7'h13, 7'h13, 7'h13, 7'h37, 7'h17, 7'h03,
             7'h23, 7'h63, 7'h73};
    ins = $urandom;
    ins[6:0] = opcs[$urandom_range(0, 11)];
    case ($urandom_range(0, 3))
      0: ins[31:25] = 7'h00;
      1: ins[31:25] = 7'h20;
      2: ins[31:25] = 7'h01;
      default: ;
    endcase
    return ins;
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'd0;
    bus.in_pc     = 32'd0;
    bus.rs1_data  = 32'd0;
    bus.rs2_data  = 32'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    started = 1'b1;
    step();
    rst = 1'b0;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_pc", bus.out_pc, 32'd0);

    xfer(32'h002081B3, 32'h0, 32'd5, 32'd7);  // ADD x3,x1,x2
    chk("add valid", 32'(bus.out_valid), 32'd1);
    chk("add op", 32'(bus.out_alu_op), 32'd0);
    chk("add a", bus.out_operand_a, 32'd5);
    chk("add b", bus.out_operand_b, 32'd7);
    chk("add rd", 32'(bus.out_rd), 32'd3);
    chk("add we", 32'(bus.out_reg_write), 32'd1);

    xfer(32'h40335293, 32'h4, 32'h80000000, 32'd0);  // SRAI x5,x6,3
    chk("srai op", 32'(bus.out_alu_op), 32'd5);
    chk("srai b", bus.out_operand_b, 32'd3);
    chk("srai rd", 32'(bus.out_rd), 32'd5);

    xfer(32'hFFF00093, 32'h8, 32'd0, 32'd0);  // ADDI x1,x0,-1
    chk("addi b", bus.out_operand_b, 32'hFFFFFFFF);

    xfer(32'h123450B7, 32'hC, 32'h55, 32'h66);  // LUI x1,0x12345
    chk("lui a", bus.out_operand_a, 32'd0);
    chk("lui b", bus.out_operand_b, 32'h12345000);

    xfer(32'h00001097, 32'h100, 32'd9, 32'd9);  // AUIPC x1,1
    chk("auipc a", bus.out_operand_a, 32'h100);
    chk("auipc b", bus.out_operand_b, 32'h1000);

    xfer(32'h402081B3, 32'h104, 32'd10, 32'd3);  // SUB, then stall 3 cycles
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall op", 32'(bus.out_alu_op), 32'd1);
      chk("stall a", bus.out_operand_a, 32'd10);
      chk("stall in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h002081B3;
    bus.in_pc     = 32'h108;
    bus.rs1_data  = 32'd1;
    bus.rs2_data  = 32'd2;
    bus.out_ready = 1'b1;
    #1;
    chk("release in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("b2b valid", 32'(bus.out_valid), 32'd1);
    chk("b2b op", 32'(bus.out_alu_op), 32'd0);
    chk("b2b pc", bus.out_pc, 32'h108);

    xfer(32'h022081B3, 32'h10C, 32'd4, 32'd4);  // MUL
    chk("mul illegal", 32'(bus.out_illegal), 32'd1);
    chk("mul we", 32'(bus.out_reg_write), 32'd0);
    chk("mul a", bus.out_operand_a, 32'd0);
    chk("mul rd", 32'(bus.out_rd), 32'd3);
    xfer(32'h0020B1B3, 32'h110, 32'd4, 32'd4);  // SLTU
    chk("sltu illegal", 32'(bus.out_illegal), 32'd1);
    chk("sltu b", bus.out_operand_b, 32'd0);
    xfer(32'h00208033, 32'h114, 32'd4, 32'd4);  // ADD x0,x1,x2
    chk("add x0 we", 32'(bus.out_reg_write), 32'd0);
    chk("add x0 illegal", 32'(bus.out_illegal), 32'd0);

    xfer(32'h002081B3, 32'h118, 32'd1, 32'd1);  // flush with a concurrent handshake
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0020C1B3;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("flush dropped", 32'(bus.out_valid), 32'd0);

    xfer(32'h002081B3, 32'h11C, 32'd1, 32'd1);  // reset during stall
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst valid", 32'(bus.out_valid), 32'd0);
    chk("rst pc", bus.out_pc, 32'd0);
    chk("rst a", bus.out_operand_a, 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      bus.in_instr  = rand_instr();
      bus.in_pc     = $urandom;
      bus.rs1_data  = $urandom;
      bus.rs2_data  = $urandom;
      step();
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
